// File: rtl/vector_mem_pkg.sv
// rtl/vector_mem_pkg.sv - shared constants and types for the vector memory arbiter
//
// Purpose : default memory geometry, burst length and read latency, the
//           arbiter state encoding and the burst owner encoding.
// Ports   : none (package).

package vector_mem_pkg;

    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 16;
    localparam int BURST_LEN   = 16;
    localparam int MEM_LATENCY = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BURST_F = 2'd1,
        BURST_I = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_F = 1'b0,
        OWNER_I = 1'b1
    } owner_t;

endpackage

// File: rtl/vector_memory_arbiter_if.sv
// rtl/vector_memory_arbiter_if.sv - burst requester port of the vector memory arbiter
//
// Purpose : one requester's request/grant handshake and its return data stream.
// Signals : req   - burst request, held until grant
//           addr  - burst start address, stable while req is high
//           grant - one-cycle pulse, burst accepted
//           valid - data holds a burst element this cycle
//           data  - returned element (holds last value when valid is low)
// Modports: master - the requester (memory manager)
//           slave  - the arbiter

interface vector_memory_arbiter_if;
    import vector_mem_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              grant;
    logic              valid;
    logic [DATA_W-1:0] data;

    modport master (
        output req,
        output addr,
        input  grant,
        input  valid,
        input  data
    );

    modport slave (
        input  req,
        input  addr,
        output grant,
        output valid,
        output data
    );

endinterface

// File: rtl/burst_address_counter.sv
// rtl/burst_address_counter.sv - burst address generator with wrap and last-element flag
//
// Purpose : loads a start address and clears the element count on load, then
//           steps the address by one per advance, wrapping modulo 2^ADDR_W.
// Ports   : clock      in  - rising-edge clock
//           clear      in  - synchronous active-high reset
//           load       in  - start a new burst at start_addr
//           start_addr in  - burst start address
//           advance    in  - step to the next element
//           addr       out - current element address (registered)
//           last       out - current element is element BURST_LEN-1

module burst_address_counter
    import vector_mem_pkg::*;
(
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CNT_W-1:0] count;

    always_ff @(posedge clock) begin
        if (clear) begin
            addr  <= '0;
            count <= '0;
        end else if (load) begin
            addr  <= start_addr;
            count <= '0;
        end else if (advance) begin
            // Natural overflow of the ADDR_W-bit sum gives the 511 -> 0 wrap.
            addr  <= addr + 1'b1;
            count <= count + 1'b1;
        end
    end

    assign last = (count == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/vector_memory_arbiter.sv
// rtl/vector_memory_arbiter.sv - two-port burst arbiter for the read-only vector memory
//
// Purpose : grants the filter and image ports fixed-length bursts of
//           consecutive addresses on the shared vector memory and steers the
//           read data back to the burst owner with a per-element valid.
// Ports   : clock       in  - rising-edge clock
//           clear       in  - synchronous active-high reset
//           f_port      if  - filter requester (slave side)
//           i_port      if  - image requester (slave side)
//           mem_address out - memory address
//           mem_enable  out - memory read enable
//           mem_write   out - always 0 (memory is read-only)
//           mem_data    in  - memory read data, MEM_LATENCY cycles after address
//           busy        out - a burst is issuing or read data is still in flight
// Config  : FILTER_PRIORITY_EN - when defined, the filter port always wins a
//           tie; otherwise ties are resolved round-robin.

module vector_memory_arbiter
    import vector_mem_pkg::*;
(
    input  logic                    clock,
    input  logic                    clear,
    vector_memory_arbiter_if.slave  f_port,
    vector_memory_arbiter_if.slave  i_port,
    output logic [ADDR_W-1:0]       mem_address,
    output logic                    mem_enable,
    output logic                    mem_write,
    input  logic [DATA_W-1:0]       mem_data,
    output logic                    busy
);

    arb_state_t        state;
    logic              f_grant;
    logic              i_grant;
`ifndef FILTER_PRIORITY_EN
    owner_t            last_served;
`endif

    logic              cnt_last;
    logic              arb_slot;
    logic              start_burst;
    logic              pick_f;
    logic              advance;
    logic [ADDR_W-1:0] start_addr;

    // ------------------------------------------------------------------
    // Arbitration. A new burst may start from IDLE or on the last address
    // cycle of the running burst, which is what makes back-to-back bursts
    // gapless. Requests seen mid-burst are otherwise ignored.
    // ------------------------------------------------------------------
    always_comb begin
        pick_f = 1'b0;
`ifdef FILTER_PRIORITY_EN
        pick_f = f_port.req;
`else
        pick_f = f_port.req && (!i_port.req || (last_served == OWNER_I));
`endif
        arb_slot    = (state == IDLE) || cnt_last;
        start_burst = arb_slot && (f_port.req || i_port.req);
        start_addr  = pick_f ? f_port.addr : i_port.addr;
        advance     = (state != IDLE) && !cnt_last;
    end

    burst_address_counter u_counter (
        .clock      (clock),
        .clear      (clear),
        .load       (start_burst),
        .start_addr (start_addr),
        .advance    (advance),
        .addr       (mem_address),
        .last       (cnt_last)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            f_grant     <= 1'b0;
            i_grant     <= 1'b0;
            mem_enable  <= 1'b0;
`ifndef FILTER_PRIORITY_EN
            last_served <= OWNER_I;
`endif
        end else begin
            f_grant <= start_burst && pick_f;
            i_grant <= start_burst && !pick_f;
            if (start_burst) begin
                state      <= pick_f ? BURST_F : BURST_I;
                mem_enable <= 1'b1;
`ifndef FILTER_PRIORITY_EN
                last_served <= pick_f ? OWNER_F : OWNER_I;
`endif
            end else if (arb_slot) begin
                state      <= IDLE;
                mem_enable <= 1'b0;
            end
        end
    end

    assign mem_write    = 1'b0;
    assign f_port.grant = f_grant;
    assign i_port.grant = i_grant;

    // ------------------------------------------------------------------
    // Return path. Each issued address pushes {valid, owner} into a shift
    // register as deep as the memory latency, so the tail lines up with
    // the data on mem_data. Clearing it drops anything already in flight.
    // ------------------------------------------------------------------
    logic   [MEM_LATENCY-1:0] pipe_valid;
    owner_t                   pipe_owner [MEM_LATENCY];
    owner_t                   cur_owner;

    assign cur_owner = (state == BURST_I) ? OWNER_I : OWNER_F;

    always_ff @(posedge clock) begin
        if (clear) begin
            for (int s = 0; s < MEM_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_owner[s] <= OWNER_F;
            end
        end else begin
            pipe_valid[0] <= mem_enable;
            pipe_owner[0] <= cur_owner;
            for (int s = 1; s < MEM_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_owner[s] <= pipe_owner[s-1];
            end
        end
    end

    logic              f_valid;
    logic              i_valid;
    logic [DATA_W-1:0] f_hold;
    logic [DATA_W-1:0] i_hold;

    assign f_valid = pipe_valid[MEM_LATENCY-1] && (pipe_owner[MEM_LATENCY-1] == OWNER_F);
    assign i_valid = pipe_valid[MEM_LATENCY-1] && (pipe_owner[MEM_LATENCY-1] == OWNER_I);

    // The element is passed straight through in its valid cycle; the hold
    // registers keep the non-owner's output at its previous element.
    always_ff @(posedge clock) begin
        if (clear) begin
            f_hold <= '0;
            i_hold <= '0;
        end else begin
            if (f_valid) f_hold <= mem_data;
            if (i_valid) i_hold <= mem_data;
        end
    end

    assign f_port.valid = f_valid;
    assign i_port.valid = i_valid;
    assign f_port.data  = f_valid ? mem_data : f_hold;
    assign i_port.data  = i_valid ? mem_data : i_hold;

    assign busy = (state != IDLE) || (|pipe_valid);

endmodule

// File: tb/tb_vector_memory_arbiter.sv
// tb/tb_vector_memory_arbiter.sv - self-checking bench for vector_memory_arbiter

module tb_vector_memory_arbiter;
    import vector_mem_pkg::*;

    logic              clock = 1'b0;
    logic              clear = 1'b1;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_enable;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data = '0;
    logic              busy;

    vector_memory_arbiter_if f_if ();
    vector_memory_arbiter_if i_if ();

    vector_memory_arbiter dut (
        .clock       (clock),
        .clear       (clear),
        .f_port      (f_if),
        .i_port      (i_if),
        .mem_address (mem_address),
        .mem_enable  (mem_enable),
        .mem_write   (mem_write),
        .mem_data    (mem_data),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    logic [DATA_W-1:0] mem [512];
    initial for (int a = 0; a < 512; a++) mem[a] = 16'h1000 + 16'(a);

    always @(posedge clock) if (mem_enable) mem_data <= mem[mem_address];

    int passed = 0;
    int total  = 0;
    bit started = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { logic own; logic [ADDR_W-1:0] a; } ent_t;
    ent_t pend[$];
    logic              m_en = 0, m_own = 0, m_fg = 0, m_ig = 0, m_fv = 0, m_iv = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [DATA_W-1:0] m_fd = '0, m_id = '0;
    logic              m_last_i = 1;

    always @(posedge clock) begin
        logic pf;
        ent_t e;
        cyc++;
        if (clear) begin
            pend.delete();
            m_en = 0; m_addr = '0; m_fg = 0; m_ig = 0; m_fv = 0; m_iv = 0;
            m_fd = '0; m_id = '0; m_last_i = 1;
        end else begin
            m_fv = m_en && !m_own;
            m_iv = m_en && m_own;
            if (m_fv) m_fd = mem[m_addr];
            if (m_iv) m_id = mem[m_addr];
            m_fg = 0; m_ig = 0;
            if (pend.size() == 0 && (f_if.req || i_if.req)) begin
`ifdef FILTER_PRIORITY_EN
                pf = f_if.req;
`else
                pf = f_if.req && (!i_if.req || m_last_i);
`endif
                for (int k = 0; k < BURST_LEN; k++)
                    pend.push_back('{own: !pf, a: (pf ? f_if.addr : i_if.addr) + ADDR_W'(k)});
                m_fg = pf; m_ig = !pf; m_last_i = !pf;
            end
            if (pend.size() != 0) begin
                e = pend.pop_front();
                m_en = 1; m_addr = e.a; m_own = e.own;
            end else begin
                m_en = 0;
            end
        end
    end

    int n_fgrant = 0, n_igrant = 0;
    always @(negedge clock) if (started) begin
        chk("f_grant", f_if.grant, m_fg);
        chk("i_grant", i_if.grant, m_ig);
        chk("mem_enable", mem_enable, m_en);
        if (m_en) chk("mem_address", mem_address, m_addr);
        chk("mem_write", mem_write, 0);
        chk("f_valid", f_if.valid, m_fv);
        chk("i_valid", i_if.valid, m_iv);
        chk("f_data", f_if.data, m_fd);
        chk("i_data", i_if.data, m_id);
        chk("busy", busy, m_en || m_fv || m_iv);
        if (f_if.grant) n_fgrant++;
        if (i_if.grant) n_igrant++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n = 1);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic gq[$];
    int   gcyc[$];
    int   base_i;

    initial begin
        f_if.req = 0; f_if.addr = '0;
        i_if.req = 0; i_if.addr = '0;
        step();
        started = 1;
        step();
        clear = 0;
        chk("rst_enable", mem_enable, 0);
        chk("rst_address", mem_address, 0);
        chk("rst_busy", busy, 0);
        step(2);

        // single filter burst at 0x020
        f_if.req = 1; f_if.addr = 9'h020;
        step();
        chk("t1_grant", f_if.grant, 1);
        chk("t1_addr0", mem_address, 9'h020);
        f_if.req = 0;
        step();
        chk("t1_fvalid0", f_if.valid, 1);
        chk("t1_fdata0", f_if.data, 16'h1020);
        chk("t1_grant_pulse", f_if.grant, 0);
        step(15);
        chk("t1_fdata15", f_if.data, 16'h102F);
        chk("t1_ivalid", i_if.valid, 0);
        step();
        chk("t1_end_valid", f_if.valid, 0);
        chk("t1_end_busy", busy, 0);
        step(3);

        // tie right after clear, both held
        clear = 1;
        step();
        clear = 0;
        f_if.req = 1; f_if.addr = 9'h080;
        i_if.req = 1; i_if.addr = 9'h0C0;
        for (int t = 0; t < 200 && gq.size() < 4; t++) begin
            step();
            if (f_if.grant) begin gq.push_back(0); gcyc.push_back(cyc); end
            if (i_if.grant) begin gq.push_back(1); gcyc.push_back(cyc); end
        end
        f_if.req = 0; i_if.req = 0;
        chk("t2_grant_count", gq.size(), 4);
        if (gq.size() == 4) begin
`ifdef FILTER_PRIORITY_EN
            chk("t2_order0", gq[0], 0); chk("t2_order1", gq[1], 0);
            chk("t2_order2", gq[2], 0); chk("t2_order3", gq[3], 0);
`else
            chk("t2_order0", gq[0], 0); chk("t2_order1", gq[1], 1);
            chk("t2_order2", gq[2], 0); chk("t2_order3", gq[3], 1);
`endif
            chk("t2_gap1", gcyc[1] - gcyc[0], 16);
            chk("t2_gap3", gcyc[3] - gcyc[2], 16);
        end
        step(20);

        // image burst wrapping past 0x1FF
        i_if.req = 1; i_if.addr = 9'h1F8;
        step();
        chk("t3_grant", i_if.grant, 1);
        chk("t3_addr0", mem_address, 9'h1F8);
        i_if.req = 0;
        step(8);
        chk("t3_wrap_addr", mem_address, 9'h000);
        step();
        chk("t3_wrap_data", i_if.data, 16'h1000);
        chk("t3_fvalid", f_if.valid, 0);
        step(12);

        // clear on the 5th address cycle of a burst
        f_if.req = 1; f_if.addr = 9'h100;
        step();
        f_if.req = 0;
        step(4);
        chk("t4_addr4", mem_address, 9'h104);
        clear = 1;
        step();
        clear = 0;
        chk("t4_enable", mem_enable, 0);
        chk("t4_fvalid", f_if.valid, 0);
        chk("t4_busy", busy, 0);
        chk("t4_fdata", f_if.data, 0);
        chk("t4_address", mem_address, 0);
        step(20);

        // withdrawn image request during a filter burst
        base_i = n_igrant;
        f_if.req = 1; f_if.addr = 9'h040;
        step();
        f_if.req = 0;
        step(3);
        i_if.req = 1; i_if.addr = 9'h050;
        step(2);
        i_if.req = 0;
        step(11);
        chk("t5_busy_tail", busy, 1);
        step();
        chk("t5_busy_low", busy, 0);
        step(5);
        chk("t5_no_igrant", n_igrant - base_i, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
